rr_burst_sched: RTL and testbench

- Round-robin scheduler that shares one burst-capable resource (memory port, bus master slot) among N requesters.
- Unlike a single-cycle grant arbiter, it locks the grant for a whole multi-beat burst and counts beats against the winner's declared length.
- The priority pointer advances only after the burst completes.
- Sits between requester front-ends and the shared datapath's beat handshake.

---
 rtl/rr_burst_sched_if.sv | 37 +++
 rtl/rr_burst_sched.sv | 125 ++++++++++++
 tb/tb_rr_burst_sched.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_burst_sched_if.sv
// Requester/datapath-facing bundle of the burst scheduler.
// The wt field exists only when WEIGHTED_RR_EN is defined.
interface rr_burst_sched_if #(
  parameter int N     = 4,
  parameter int LEN_W = 4,
  parameter int WT_W  = 2
);
  localparam int ID_W = $clog2(N);

  logic [N-1:0]       req;
  logic [N*LEN_W-1:0] req_len;
  logic               beat_vld;
  logic [N-1:0]       gnt;
  logic [ID_W-1:0]    gnt_id;
  logic               gnt_vld;
  logic [LEN_W-1:0]   beat_cnt;
  logic               last;
`ifdef WEIGHTED_RR_EN
  logic [N*WT_W-1:0]  wt;
`endif

  modport master (
`ifdef WEIGHTED_RR_EN
    output wt,
`endif
    output req, req_len, beat_vld,
    input  gnt, gnt_id, gnt_vld, beat_cnt, last
  );

  modport slave (
`ifdef WEIGHTED_RR_EN
    input  wt,
`endif
    input  req, req_len, beat_vld,
    output gnt, gnt_id, gnt_vld, beat_cnt, last
  );
endinterface

// File: rtl/rr_burst_sched.sv
// Round-robin scheduler that locks a grant for a burst of len+1 beats; pointer advances at burst end.
// Optional: define WEIGHTED_RR_EN for per-grant credits that re-grant the same requester.
module rr_burst_sched #(
  parameter int N     = 4,
  parameter int LEN_W = 4,
  parameter int WT_W  = 2
) (
  input logic             clk,
  input logic             rst_n,
  rr_burst_sched_if.slave bus
);
  localparam int ID_W  = $clog2(N);
  localparam int IDX_W = ID_W + 1;

  typedef enum logic [0:0] {IDLE = 1'b0, BURST = 1'b1} state_t;

  if (N < 2 || N > 16 || LEN_W < 1 || WT_W < 1) begin : g_param_check
    $error("rr_burst_sched: parameter out of range");
  end

  state_t           state_q;
  logic [N-1:0]     gnt_q;
  logic [ID_W-1:0]  gnt_id_q;
  logic [ID_W-1:0]  ptr_q;
  logic             gnt_vld_q;
  logic [LEN_W-1:0] beat_cnt_q;
  logic [LEN_W-1:0] len_q;

  logic             last_s;
  logic             found_s;
  logic             hold_s;
  logic             load_s;
  logic [ID_W-1:0]  ptr_adv_s;
  logic [ID_W-1:0]  arb_ptr_s;
  logic [ID_W-1:0]  win_s;
  logic [ID_W-1:0]  tgt_s;
  logic [IDX_W-1:0] pick_s;
  logic [N-1:0]     tgt_oh_s;
  logic [LEN_W-1:0] tgt_len_s;

  // Returns {found, index} of the first set request at or after p, wrapping modulo N.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [N-1:0] r, input logic [ID_W-1:0] p);
    logic [IDX_W-1:0] res;
    logic [IDX_W-1:0] sum;
    logic [IDX_W-1:0] idx;
    res = {IDX_W{1'b0}};
    for (int k = N - 1; k >= 0; k--) begin
      sum = {1'b0, p} + IDX_W'(k);
      idx = (sum >= IDX_W'(N)) ? sum - IDX_W'(N) : sum;
      res = r[idx[ID_W-1:0]] ? {1'b1, idx[ID_W-1:0]} : res;
    end
    return res;
  endfunction

  // On a completing beat arbitration already uses the advanced pointer, so the next burst starts without a bubble.
  always_comb begin
    last_s    = (state_q == BURST) && bus.beat_vld && (beat_cnt_q == len_q);
    ptr_adv_s = (gnt_id_q == ID_W'(N - 1)) ? {ID_W{1'b0}} : gnt_id_q + ID_W'(1);
    arb_ptr_s = (state_q == BURST) ? ptr_adv_s : ptr_q;
    pick_s    = rr_pick(bus.req, arb_ptr_s);
    found_s   = pick_s[ID_W];
    win_s     = pick_s[ID_W-1:0];
    tgt_s     = hold_s ? gnt_id_q : win_s;
    tgt_oh_s  = {{(N-1){1'b0}}, 1'b1} << tgt_s;
    tgt_len_s = bus.req_len[tgt_s*LEN_W +: LEN_W];
    load_s    = hold_s || (found_s && ((state_q == IDLE) || last_s));
  end

`ifdef WEIGHTED_RR_EN
  logic [WT_W-1:0] credit_q;

  assign hold_s = last_s && (credit_q != {WT_W{1'b0}}) && bus.req[gnt_id_q];

  // A fresh grant loads the winner's weight; each re-grant spends one credit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_q <= {WT_W{1'b0}};
    end else if (load_s) begin
      credit_q <= hold_s ? credit_q - WT_W'(1) : bus.wt[tgt_s*WT_W +: WT_W];
    end
  end
`else
  assign hold_s = 1'b0;
`endif

  // Scheduler state: grant, latched length, beat counter and priority pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= {N{1'b0}};
      gnt_id_q   <= {ID_W{1'b0}};
      gnt_vld_q  <= 1'b0;
      beat_cnt_q <= {LEN_W{1'b0}};
      len_q      <= {LEN_W{1'b0}};
      ptr_q      <= {ID_W{1'b0}};
    end else begin
      if (load_s) begin
        state_q    <= BURST;
        gnt_q      <= tgt_oh_s;
        gnt_id_q   <= tgt_s;
        gnt_vld_q  <= 1'b1;
        len_q      <= tgt_len_s;
        beat_cnt_q <= {LEN_W{1'b0}};
      end else if (last_s) begin
        state_q    <= IDLE;
        gnt_q      <= {N{1'b0}};
        gnt_id_q   <= {ID_W{1'b0}};
        gnt_vld_q  <= 1'b0;
        len_q      <= {LEN_W{1'b0}};
        beat_cnt_q <= {LEN_W{1'b0}};
      end else if ((state_q == BURST) && bus.beat_vld) begin
        beat_cnt_q <= beat_cnt_q + LEN_W'(1);
      end
      if (last_s && !hold_s) begin
        ptr_q <= ptr_adv_s;
      end
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.gnt_id   = gnt_id_q;
  assign bus.gnt_vld  = gnt_vld_q;
  assign bus.beat_cnt = beat_cnt_q;
  assign bus.last     = last_s;
endmodule

// File: tb/tb_rr_burst_sched.sv
// Self-checking bench for rr_burst_sched: directed scenarios plus random traffic against a burst-level model.
module tb_rr_burst_sched;
  localparam int N     = 4;
  localparam int LEN_W = 4;
  localparam int WT_W  = 2;
`ifdef WEIGHTED_RR_EN
  localparam bit WEIGHTED = 1'b1;
`else
  localparam bit WEIGHTED = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;
  logic [N*WT_W-1:0] wt_s;

  rr_burst_sched_if #(.N(N), .LEN_W(LEN_W), .WT_W(WT_W)) bus ();

  rr_burst_sched #(.N(N), .LEN_W(LEN_W), .WT_W(WT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef WEIGHTED_RR_EN
  assign bus.wt = wt_s;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: who owns the resource, how many beats it declared and has done, where priority starts.
  typedef struct {
    bit busy;
    int owner;
    int len;
    int cnt;
    int ptr;
    int credit;
  } model_t;

  model_t m_q;

  function automatic model_t model_next(model_t m, logic [N-1:0] r, logic [N*LEN_W-1:0] lens,
                                        logic bv, logic [N*WT_W-1:0] w);
    model_t n;
    int pick;
    n = m;
    if (m.busy) begin
      if (!bv) return n;
      if (m.cnt < m.len) begin
        n.cnt = m.cnt + 1;
        return n;
      end
      if (WEIGHTED && m.credit > 0 && r[m.owner]) begin
        n.cnt    = 0;
        n.len    = int'(lens[m.owner*LEN_W +: LEN_W]);
        n.credit = m.credit - 1;
        return n;
      end
      n.ptr = (m.owner + 1) % N;
    end
    pick = -1;
    for (int k = 0; k < N; k++)
      if (pick < 0 && r[(n.ptr + k) % N]) pick = (n.ptr + k) % N;
    n.cnt = 0;
    if (pick < 0) begin
      n.busy = 1'b0;
      return n;
    end
    n.busy   = 1'b1;
    n.owner  = pick;
    n.len    = int'(lens[pick*LEN_W +: LEN_W]);
    n.credit = WEIGHTED ? int'(w[pick*WT_W +: WT_W]) : 0;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_q <= '{default: 0};
    else        m_q <= model_next(m_q, bus.req, bus.req_len, bus.beat_vld, wt_s);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n        = 1'b0;
    bus.req      = 4'b0000;
    bus.req_len  = 16'h0000;
    bus.beat_vld = 1'b0;
    wt_s         = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({bus.gnt, bus.gnt_vld, bus.gnt_id, bus.beat_cnt, bus.last} !== 12'h000) begin
      n_fail++;
      $display("FAIL reset_state: gnt=%b vld=%b id=%0d cnt=%0d last=%b, expected all zero",
               bus.gnt, bus.gnt_vld, bus.gnt_id, bus.beat_cnt, bus.last);
    end
  endtask

  task automatic test_basic();
    do_reset();
    bus.req     = 4'b0110;
    bus.req_len = {4{4'd2}};
    step();
    n_tests++;
    if ({bus.gnt, bus.gnt_vld, bus.gnt_id} !== {4'b0010, 1'b1, 2'd1}) begin
      n_fail++;
      $display("FAIL basic_first_grant: gnt=%b vld=%b id=%0d, expected 0010 1 1", bus.gnt, bus.gnt_vld, bus.gnt_id);
    end
    bus.beat_vld = 1'b1;
    for (int b = 0; b < 3; b++) begin
      #1;
      n_tests++;
      if ({bus.beat_cnt, bus.last} !== {4'(b), (b == 2)}) begin
        n_fail++;
        $display("FAIL basic_beat%0d: cnt=%0d last=%b, expected %0d %b", b, bus.beat_cnt, bus.last, b, (b == 2));
      end
      step();
    end
    n_tests++;
    if ({bus.gnt, bus.beat_cnt} !== {4'b0100, 4'd0}) begin
      n_fail++;
      $display("FAIL basic_back_to_back: gnt=%b cnt=%0d, expected 0100 0", bus.gnt, bus.beat_cnt);
    end
  endtask

  task automatic test_rotate();
    logic [N-1:0] e;
    do_reset();
    bus.req      = 4'b1111;
    bus.beat_vld = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      e = 4'b0001 << (k % N);
      n_tests++;
      if ({bus.gnt, bus.last} !== {e, 1'b1}) begin
        n_fail++;
        $display("FAIL rotate_%0d: gnt=%b last=%b, expected %b 1", k, bus.gnt, bus.last, e);
      end
      step();
    end
  endtask

  task automatic test_lock();
    do_reset();
    bus.req     = 4'b0010;
    bus.req_len = 16'h0030;
    step();
    bus.beat_vld = 1'b1;
    step();
    bus.req     = 4'b1101;
    bus.req_len = 16'h0000;
    step();
    n_tests++;
    if ({bus.gnt, bus.beat_cnt, bus.last} !== {4'b0010, 4'd2, 1'b0}) begin
      n_fail++;
      $display("FAIL lock_held: gnt=%b cnt=%0d last=%b, expected 0010 2 0", bus.gnt, bus.beat_cnt, bus.last);
    end
    step();
    n_tests++;
    if ({bus.gnt, bus.beat_cnt, bus.last} !== {4'b0010, 4'd3, 1'b1}) begin
      n_fail++;
      $display("FAIL lock_fourth_beat: gnt=%b cnt=%0d last=%b, expected 0010 3 1", bus.gnt, bus.beat_cnt, bus.last);
    end
    step();
    n_tests++;
    if (bus.gnt !== 4'b0100) begin
      n_fail++;
      $display("FAIL lock_pointer: gnt=%b, expected 0100", bus.gnt);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.req     = 4'b0001;
    bus.req_len = 16'h0003;
    step();
    bus.beat_vld = 1'b1;
    step();
    step();
    n_tests++;
    if (bus.beat_cnt !== 4'd2) begin
      n_fail++;
      $display("FAIL midreset_pre: cnt=%0d, expected 2", bus.beat_cnt);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if ({bus.gnt, bus.gnt_vld, bus.gnt_id, bus.beat_cnt, bus.last} !== 12'h000) begin
      n_fail++;
      $display("FAIL midreset_clear: gnt=%b vld=%b id=%0d cnt=%0d last=%b, expected all zero",
               bus.gnt, bus.gnt_vld, bus.gnt_id, bus.beat_cnt, bus.last);
    end
    @(negedge clk);
    rst_n        = 1'b1;
    bus.beat_vld = 1'b0;
    bus.req_len  = 16'h0000;
    bus.req      = 4'b1000;
    step();
    n_tests++;
    if ({bus.gnt, bus.gnt_id} !== {4'b1000, 2'd3}) begin
      n_fail++;
      $display("FAIL midreset_regrant: gnt=%b id=%0d, expected 1000 3", bus.gnt, bus.gnt_id);
    end
    bus.req      = 4'b1001;
    bus.beat_vld = 1'b1;
    step();
    n_tests++;
    if (bus.gnt !== 4'b0001) begin
      n_fail++;
      $display("FAIL midreset_pointer: gnt=%b, expected 0001", bus.gnt);
    end
  endtask

  task automatic test_idle_beats();
    do_reset();
    bus.beat_vld = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      n_tests++;
      if ({bus.gnt, bus.gnt_vld, bus.beat_cnt, bus.last} !== 10'h000) begin
        n_fail++;
        $display("FAIL idle_beat%0d: gnt=%b vld=%b cnt=%0d last=%b, expected all zero",
                 k, bus.gnt, bus.gnt_vld, bus.beat_cnt, bus.last);
      end
      step();
    end
  endtask

`ifdef WEIGHTED_RR_EN
  task automatic test_weighted();
    int exp_ids [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    do_reset();
    wt_s         = 8'b00_00_00_10;
    bus.req      = 4'b0011;
    bus.beat_vld = 1'b1;
    step();
    for (int k = 0; k < 8; k++) begin
      n_tests++;
      if ({bus.gnt_vld, bus.gnt_id} !== {1'b1, 2'(exp_ids[k])}) begin
        n_fail++;
        $display("FAIL weighted_%0d: vld=%b id=%0d, expected 1 %0d", k, bus.gnt_vld, bus.gnt_id, exp_ids[k]);
      end
      step();
    end
  endtask
`endif

  task automatic test_random();
    logic [N-1:0] eg;
    logic         el;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom_range(0, 15));
      bus.req_len  = 16'($urandom) & 16'h3333;
      bus.beat_vld = ($urandom_range(0, 3) != 0);
      wt_s         = 8'($urandom);
      #1;
      el = m_q.busy && bus.beat_vld && (m_q.cnt == m_q.len);
      n_tests++;
      if (bus.last !== el) begin
        n_fail++;
        $display("FAIL random_last c=%0d: last=%b, expected %b", c, bus.last, el);
      end
      step();
      eg = m_q.busy ? (4'b0001 << m_q.owner) : 4'b0000;
      n_tests++;
      if ({bus.gnt, bus.gnt_vld, bus.beat_cnt} !== {eg, m_q.busy, 4'(m_q.cnt)}) begin
        n_fail++;
        $display("FAIL random_state c=%0d: gnt=%b vld=%b cnt=%0d, expected %b %b %0d",
                 c, bus.gnt, bus.gnt_vld, bus.beat_cnt, eg, m_q.busy, m_q.cnt);
      end
      if (m_q.busy) begin
        n_tests++;
        if (bus.gnt_id !== 2'(m_q.owner)) begin
          n_fail++;
          $display("FAIL random_id c=%0d: id=%0d, expected %0d", c, bus.gnt_id, m_q.owner);
        end
      end
    end
  endtask

  initial begin
    n_tests      = 0;
    n_fail       = 0;
    rst_n        = 1'b0;
    bus.req      = 4'b0000;
    bus.req_len  = 16'h0000;
    bus.beat_vld = 1'b0;
    wt_s         = 8'h00;
    test_reset();
    test_basic();
    test_rotate();
    test_lock();
    test_reset_mid();
    test_idle_beats();
`ifdef WEIGHTED_RR_EN
    test_weighted();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
